// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the pipeline and the iterative mul/div unit.
// The master drives operations in and the slave returns status and the HI/LO result.
interface alu_muldiv_seq_if #(
    parameter int DATA_W = 32
) ();
    logic              flush;
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              ready;
    logic              busy;
    logic              done;
    logic              hilo_we;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output flush, start, op, data1, data2,
        input  ready, busy, done, hilo_we, hi, lo
    );

    modport slave (
        input  flush, start, op, data1, data2,
        output ready, busy, done, hilo_we, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply / restoring divide producing the HI/LO pair.
// Signed operations run on magnitudes; signs are applied in a single fix-up cycle.
module alu_muldiv_seq #(
    parameter int DATA_W = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    alu_muldiv_seq_if.slave    bus
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_q;
    logic [1:0]          op_q;
    logic                s1_q;
    logic                s2_q;
    logic [DATA_W-1:0]   opnd_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [CW-1:0]       count_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic [DATA_W-1:0]   mag1_d;
    logic [DATA_W-1:0]   mag2_d;
    logic                neg1_d;
    logic                neg2_d;
    logic [DATA_W:0]     mul_sum_d;
    logic [2*DATA_W-1:0] mul_next_d;
    logic [DATA_W:0]     rem_sh_d;
    logic                ge_d;
    logic [DATA_W-1:0]   diff_d;
    logic [2*DATA_W-1:0] div_next_d;
    logic [2*DATA_W-1:0] prod_d;
    logic [DATA_W-1:0]   fix_hi_d;
    logic [DATA_W-1:0]   fix_lo_d;

    // Magnitudes of the incoming operands; MIN maps to itself as an unsigned value.
    assign neg1_d = bus.op[0] & bus.data1[DATA_W-1];
    assign neg2_d = bus.op[0] & bus.data2[DATA_W-1];
    assign mag1_d = neg1_d ? -bus.data1 : bus.data1;
    assign mag2_d = neg2_d ? -bus.data2 : bus.data2;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    assign mul_sum_d  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next_d = {mul_sum_d, acc_q[DATA_W-1:1]};

    // Divide step: acc = {remainder, dividend bits shifting out / quotient bits in}.
    assign rem_sh_d   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign ge_d       = rem_sh_d >= {1'b0, opnd_q};
    assign diff_d     = rem_sh_d[DATA_W-1:0] - opnd_q;
    assign div_next_d = {ge_d ? diff_d : rem_sh_d[DATA_W-1:0], acc_q[DATA_W-2:0], ge_d};

    always_comb begin
        prod_d   = ((op_q == 2'd1) && (s1_q ^ s2_q)) ? -acc_q : acc_q;
        fix_hi_d = prod_d[2*DATA_W-1:DATA_W];
        fix_lo_d = prod_d[DATA_W-1:0];
        if (op_q[1]) begin
            // Remainder always follows the dividend's sign; with a zero divisor it
            // still holds |dividend|, so this restores the raw dividend too.
            fix_hi_d = (op_q[0] && s1_q) ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
            if (opnd_q == '0) begin
                fix_lo_d = '1;
            end else begin
                fix_lo_d = (op_q[0] && (s1_q ^ s2_q)) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start && !bus.flush) begin
                        op_q    <= bus.op;
                        s1_q    <= neg1_d;
                        s2_q    <= neg2_d;
                        opnd_q  <= bus.op[1] ? mag2_d : mag1_d;
                        acc_q   <= {{DATA_W{1'b0}}, (bus.op[1] ? mag1_d : mag2_d)};
                        count_q <= CW'(DATA_W);
                        state_q <= S_CALC;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q   <= op_q[1] ? div_next_d : mul_next_d;
                        count_q <= count_q - CW'(1);
                        if (count_q == CW'(1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        hi_q    <= fix_hi_d;
                        lo_q    <= fix_lo_d;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.busy    = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done    = (state_q == S_DONE);
    assign bus.hilo_we = (state_q == S_DONE);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule
